// File: rtl/bcd_accum_seq.sv
// bcd_accum_seq: sequenced two-digit BCD accumulator driving two active-low
// 7-segment displays. Binary operands (0-15) are accepted over a valid/ready
// handshake and added to a running decimal total (00-99). Decimal correction
// is applied one digit per cycle: ones first, then tens.
//
// Ports:
//   Clock     system clock, all state updates on the rising edge
//   Reset     synchronous active-high reset
//   In        binary operand, 0-15
//   InValid   operand present on In
//   Clear     request to zero the total and Overflow (IDLE only)
//   InReady   block accepts an operand or Clear this cycle (IDLE)
//   Busy      sequencing in progress (ONES, TENS, DONE)
//   Done      one-cycle pulse after the total has been updated
//   Overflow  sticky flag: total exceeded 99 since the last Clear/Reset
//   Digit1    tens BCD digit
//   Digit0    ones BCD digit
//   HEX1      active-low segments {g,f,e,d,c,b,a} for Digit1
//   HEX0      active-low segments {g,f,e,d,c,b,a} for Digit0
module bcd_accum_seq (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] In,
  input  logic       InValid,
  input  logic       Clear,
  output logic       InReady,
  output logic       Busy,
  output logic       Done,
  output logic       Overflow,
  output logic [3:0] Digit1,
  output logic [3:0] Digit0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam int unsigned DigitW = 4;
  localparam int unsigned SegW   = 7;
  localparam int unsigned CarryW = 2;
  localparam int unsigned SumW   = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ONES = 2'd1;
  localparam logic [1:0] S_TENS = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [SegW-1:0] SEG_BLANK = 7'b1111111;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DigitW-1:0] operand;
  logic [DigitW-1:0] operand_nxt;
  logic [CarryW-1:0] carry;
  logic [CarryW-1:0] carry_nxt;
  logic [DigitW-1:0] digit0_nxt;
  logic [DigitW-1:0] digit1_nxt;
  logic              overflow_nxt;

  // Ones sum is at most 9 + 15 = 24, tens sum at most 9 + 2 = 11.
  logic [SumW-1:0]   ones_sum;
  logic [DigitW-1:0] tens_sum;

  assign ones_sum = SumW'(Digit0) + SumW'(operand);
  assign tens_sum = Digit1 + DigitW'(carry);

  // Next-state and datapath update.
  always_comb begin
    state_nxt    = state;
    operand_nxt  = operand;
    carry_nxt    = carry;
    digit0_nxt   = Digit0;
    digit1_nxt   = Digit1;
    overflow_nxt = Overflow;

    case (state)
      S_IDLE: begin
        // Clear takes priority; a simultaneous operand is dropped.
        if (Clear) begin
          digit0_nxt   = '0;
          digit1_nxt   = '0;
          overflow_nxt = 1'b0;
        end else if (InValid) begin
          operand_nxt = In;
          state_nxt   = S_ONES;
        end
      end

      S_ONES: begin
        if (ones_sum >= SumW'(20)) begin
          digit0_nxt = DigitW'(ones_sum - SumW'(20));
          carry_nxt  = CarryW'(2);
        end else if (ones_sum >= SumW'(10)) begin
          digit0_nxt = DigitW'(ones_sum - SumW'(10));
          carry_nxt  = CarryW'(1);
        end else begin
          digit0_nxt = DigitW'(ones_sum);
          carry_nxt  = CarryW'(0);
        end
        state_nxt = S_TENS;
      end

      S_TENS: begin
        // Hundreds are discarded; the wrap is recorded in Overflow.
        if (tens_sum >= DigitW'(10)) begin
          digit1_nxt   = tens_sum - DigitW'(10);
          overflow_nxt = 1'b1;
        end else begin
          digit1_nxt = tens_sum;
        end
        state_nxt = S_DONE;
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and status registers. Status flags follow the next state
  // so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      operand  <= '0;
      carry    <= '0;
      Digit0   <= '0;
      Digit1   <= '0;
      Overflow <= 1'b0;
      InReady  <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      operand  <= operand_nxt;
      carry    <= carry_nxt;
      Digit0   <= digit0_nxt;
      Digit1   <= digit1_nxt;
      Overflow <= overflow_nxt;
      InReady  <= (state_nxt == S_IDLE);
      Busy     <= (state_nxt != S_IDLE);
      Done     <= (state_nxt == S_DONE);
    end
  end

  // Active-low 7-segment decode; codes 10-15 display blank.
  function automatic logic [SegW-1:0] seg_decode(input logic [DigitW-1:0] d);
    logic [SegW-1:0] seg;
    seg = SEG_BLANK;
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Displays follow the digit registers directly.
  always_comb begin
    HEX1 = seg_decode(Digit1);
    HEX0 = seg_decode(Digit0);
  end

endmodule

// File: tb/tb_bcd_accum_seq.sv
// tb_bcd_accum_seq: directed and randomized checks of bcd_accum_seq against a
// decimal-arithmetic reference model (running total modulo 100 plus a sticky
// overflow flag).
module tb_bcd_accum_seq;

  logic       Clock;
  logic       Reset;
  logic [3:0] In;
  logic       InValid;
  logic       Clear;
  logic       InReady;
  logic       Busy;
  logic       Done;
  logic       Overflow;
  logic [3:0] Digit1;
  logic [3:0] Digit0;
  logic [6:0] HEX1;
  logic [6:0] HEX0;

  bcd_accum_seq dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .In      (In),
    .InValid (InValid),
    .Clear   (Clear),
    .InReady (InReady),
    .Busy    (Busy),
    .Done    (Done),
    .Overflow(Overflow),
    .Digit1  (Digit1),
    .Digit0  (Digit0),
    .HEX1    (HEX1),
    .HEX0    (HEX0)
  );

  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int total = 0;
  bit ovf   = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_total(input string tag);
    check({tag, "_d1"},  32'(Digit1),   32'(total / 10));
    check({tag, "_d0"},  32'(Digit0),   32'(total % 10));
    check({tag, "_hx1"}, 32'(HEX1),     32'(SEG[total / 10]));
    check({tag, "_hx0"}, 32'(HEX0),     32'(SEG[total % 10]));
    check({tag, "_ovf"}, 32'(Overflow), 32'(ovf));
  endtask

  // One full add transaction; optional noise on InValid/Clear while busy.
  task automatic add_op(input int op, input bit noise);
    int new_total;
    bit new_ovf;
    new_total = total + op;
    new_ovf   = ovf;
    if (new_total > 99) begin
      new_total = new_total - 100;
      new_ovf   = 1'b1;
    end
    @(negedge Clock);
    check("add_ready_pre", 32'(InReady), 32'd1);
    In = 4'(op); InValid = 1'b1; Clear = 1'b0;
    @(negedge Clock);                       // after accept edge k
    InValid = 1'b0;
    if (noise) begin
      InValid = 1'b1;
      Clear   = 1'b1;
      In      = 4'($urandom_range(15));
    end
    check("add_k_ready", 32'(InReady), 32'd0);
    check("add_k_busy",  32'(Busy),    32'd1);
    check("add_k_done",  32'(Done),    32'd0);
    @(negedge Clock);                       // after k+1: ones updated
    check("add_k1_d0",   32'(Digit0),   32'(new_total % 10));
    check("add_k1_d1",   32'(Digit1),   32'(total / 10));
    check("add_k1_ovf",  32'(Overflow), 32'(ovf));
    check("add_k1_done", 32'(Done),     32'd0);
    check("add_k1_rdy",  32'(InReady),  32'd0);
    @(negedge Clock);                       // after k+2: Done pulse
    InValid = 1'b0;
    Clear   = 1'b0;
    total = new_total;
    ovf   = new_ovf;
    check("add_k2_done", 32'(Done),    32'd1);
    check("add_k2_busy", 32'(Busy),    32'd1);
    check("add_k2_rdy",  32'(InReady), 32'd0);
    check_total("add_k2");
    @(negedge Clock);                       // after k+3: idle again
    check("add_k3_done", 32'(Done),    32'd0);
    check("add_k3_rdy",  32'(InReady), 32'd1);
    check("add_k3_busy", 32'(Busy),    32'd0);
    check_total("add_k3");
  endtask

  // Clear from IDLE, optionally colliding with an operand.
  task automatic clear_op(input bit with_valid);
    @(negedge Clock);
    Clear = 1'b1; InValid = with_valid; In = 4'($urandom_range(1, 15));
    @(negedge Clock);
    Clear = 1'b0; InValid = 1'b0;
    total = 0;
    ovf   = 1'b0;
    check("clr_rdy",  32'(InReady), 32'd1);
    check("clr_busy", 32'(Busy),    32'd0);
    check("clr_done", 32'(Done),    32'd0);
    check_total("clr");
    repeat (3) begin
      @(negedge Clock);
      check("clr_idle_done", 32'(Done), 32'd0);
    end
    check_total("clr_after");
  endtask

  initial begin
    Reset = 1'b1; In = '0; InValid = 1'b0; Clear = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_rdy",  32'(InReady), 32'd1);
    check("rst_busy", 32'(Busy),    32'd0);
    check("rst_done", 32'(Done),    32'd0);
    check_total("rst");

    // 00 + 3 + 4
    add_op(3, 1'b0);
    add_op(4, 1'b0);

    // Carry cases
    clear_op(1'b0); add_op(9, 1'b0); add_op(5, 1'b0);      // 14
    clear_op(1'b0); add_op(9, 1'b0); add_op(15, 1'b0);     // 24
    clear_op(1'b0); add_op(15, 1'b0); add_op(4, 1'b0);     // 19
    add_op(15, 1'b0);                                      // 34

    // Overflow: build 95, +7 -> 02, +1 -> 03, then Clear
    clear_op(1'b0);
    for (int i = 0; i < 6; i++) add_op(15, 1'b0);
    add_op(5, 1'b0);
    add_op(7, 1'b0);
    add_op(1, 1'b0);
    clear_op(1'b0);

    // Clear with InValid at total 42
    add_op(15, 1'b0); add_op(15, 1'b0); add_op(12, 1'b0);
    clear_op(1'b1);

    // Noise while busy
    add_op(6, 1'b1);
    add_op(13, 1'b1);

    // Reset during TENS after 58 + 7
    clear_op(1'b0);
    add_op(15, 1'b0); add_op(15, 1'b0); add_op(15, 1'b0); add_op(13, 1'b0);
    @(negedge Clock);
    In = 4'd7; InValid = 1'b1;
    @(negedge Clock);
    InValid = 1'b0;
    @(negedge Clock);
    check("rtens_d0", 32'(Digit0), 32'd5);
    check("rtens_d1", 32'(Digit1), 32'd5);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    total = 0;
    ovf   = 1'b0;
    check("rtens_done", 32'(Done),    32'd0);
    check("rtens_rdy",  32'(InReady), 32'd1);
    check("rtens_busy", 32'(Busy),    32'd0);
    check_total("rtens");
    repeat (3) begin
      @(negedge Clock);
      check("rtens_after_done", 32'(Done), 32'd0);
    end
    check_total("rtens_after");

    // Randomized mix of adds and clears
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) == 0) clear_op(1'($urandom_range(1)));
      else add_op(int'($urandom_range(15)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
